// File: rtl/fetch_stage_if.sv
// Fetch stage bundle: hazard/control inputs, IM port and F/D register outputs.
// The fetch stage is the slave; the surrounding core (or bench) is the master.
interface fetch_stage_if;
    logic        stall;
    logic [1:0]  npc_op;
    logic [31:0] D_rs_data;
    logic [31:0] F_instr;
    logic [31:0] F_pc;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic [31:0] D_pc8;
    logic        D_valid;
    logic [31:0] fetch_cnt;

    modport master (
        output stall, npc_op, D_rs_data, F_instr,
        input  F_pc, D_instr, D_pc, D_pc8, D_valid, fetch_cnt
    );

    modport slave (
        input  stall, npc_op, D_rs_data, F_instr,
        output F_pc, D_instr, D_pc, D_pc8, D_valid, fetch_cnt
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS fetch stage: PC register, next-PC select and F/D pipeline register.
// One architectural delay slot, so no flush path exists.
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_stage_if.slave bus
);
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] dpc_q;
    logic        valid_q;
    logic [31:0] cnt_q;

    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] npc;

    // Targets are resolved from the instruction sitting in D, not the one in F.
    assign br_target = dpc_q + 32'd4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign j_target  = {dpc_q[31:28], instr_q[25:0], 2'b00};

    always_comb begin
        npc = pc_q + 32'd4;
        case (bus.npc_op)
            2'd1:    npc = br_target;
            2'd2:    npc = j_target;
            2'd3:    npc = bus.D_rs_data;
            default: npc = pc_q + 32'd4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= PC_RESET;
            instr_q <= 32'd0;
            dpc_q   <= 32'd0;
            valid_q <= 1'b0;
            cnt_q   <= 32'd0;
        end else if (!bus.stall) begin
            pc_q    <= npc;
            instr_q <= bus.F_instr;
            dpc_q   <= pc_q;
            valid_q <= 1'b1;
            cnt_q   <= cnt_q + 32'd1;
        end
    end

    assign bus.F_pc      = pc_q;
    assign bus.D_instr   = instr_q;
    assign bus.D_pc      = dpc_q;
    assign bus.D_pc8     = dpc_q + 32'd8;
    assign bus.D_valid   = valid_q;
    assign bus.fetch_cnt = cnt_q;
endmodule
